// File: rtl/tx_cic_interp_if.sv
// tx_cic_interp_if: serial control bus, input sample handshake and
// interpolated output bundle for the TX CIC interpolator.
// The master side drives the bus and feeds samples; the slave side is the interpolator.
interface tx_cic_interp_if;
    logic               enable;
    logic [6:0]         serial_addr;
    logic [31:0]        serial_data;
    logic               serial_strobe;
    logic               sample_strobe;
    logic signed [15:0] i_in;
    logic signed [15:0] q_in;
    logic               in_valid;
    logic               interp_strobe;
    logic signed [15:0] i_out;
    logic signed [15:0] q_out;
    logic               underrun;

    modport master (
        output enable, serial_addr, serial_data, serial_strobe, sample_strobe,
        output i_in, q_in, in_valid,
        input  interp_strobe, i_out, q_out, underrun
    );

    modport slave (
        input  enable, serial_addr, serial_data, serial_strobe, sample_strobe,
        input  i_in, q_in, in_valid,
        output interp_strobe, i_out, q_out, underrun
    );
endinterface

// File: rtl/tx_cic_interp.sv
// tx_cic_interp: 4-stage CIC interpolator (I and Q) for the TX path.
// Combs run at the input rate (one update per interp_strobe request), the
// integrators run at the DAC sample_strobe rate with zero-stuffing, and the
// result is scaled by 3*ceil(log2(rate)) and saturated to 16 bits.
// Optional feature: define TX_CIC_ROUND_EN to round half up before the shift;
// without it the shift truncates.
module tx_cic_interp #(
    parameter logic [6:0] RATEADDR = 7'd0
) (
    input  logic           clock,
    input  logic           reset,
    tx_cic_interp_if.slave bus
);
    localparam int W = 40;
    localparam int N = 4;
    localparam logic signed [W:0] ROUND_ONE = 41'sd1;

    logic        rate_wr;
    logic        flush;
    logic        strobe_ok;
    logic        wrap;
    logic [7:0]  rate;
    logic [7:0]  rate_wdata;
    logic [7:0]  rate_m1;
    logic [7:0]  count;
    logic        interp_q;
    logic        load_q;
    logic        underrun_q;
    logic        pending;
    logic        unused_data_bits;

    logic signed [W-1:0] comb_x   [2];
    logic signed [W-1:0] comb_c   [2][N+1];
    logic signed [W-1:0] comb_dly [2][N];
    logic signed [W-1:0] comb_lat [2];
    logic signed [W-1:0] integ    [2][N];

    logic [3:0]          log2_rate;
    logic [4:0]          shift;
    logic signed [W:0]   biased  [2];
    logic signed [W:0]   shifted [2];
    logic signed [15:0]  y       [2];
    logic signed [15:0]  out_q   [2];

    // A rate write hits only our register address; 0 and 1 are clamped to 2.
    assign rate_wr          = bus.serial_strobe && (bus.serial_addr == RATEADDR);
    assign rate_wdata       = (bus.serial_data[7:1] == 7'd0) ? 8'd2 : bus.serial_data[7:0];
    assign unused_data_bits = ^bus.serial_data[31:8];

    // Either a disabled path or a rate change wipes the counter and filter state.
    assign flush     = !bus.enable || rate_wr;
    assign strobe_ok = bus.sample_strobe && !flush;
    assign rate_m1   = rate - 8'd1;
    assign wrap      = (count == rate_m1);

    assign bus.interp_strobe = interp_q;
    assign bus.underrun      = underrun_q;
    assign bus.i_out         = out_q[0];
    assign bus.q_out         = out_q[1];

    // Interpolation-rate register; survives enable going low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rate <= 8'd4;
        end else if (rate_wr) begin
            rate <= rate_wdata;
        end
    end

    // Divide sample_strobe by rate and raise a one-clock request after the wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count    <= 8'd0;
            interp_q <= 1'b0;
        end else if (flush) begin
            count    <= 8'd0;
            interp_q <= 1'b0;
        end else begin
            interp_q <= bus.sample_strobe && wrap;
            if (bus.sample_strobe) begin
                count <= wrap ? 8'd0 : count + 8'd1;
            end
        end
    end

    // Comb cascade: sign-extended sample (or zero on underrun) minus each stage's delay.
    always_comb begin
        comb_x[0] = bus.in_valid ? {{(W-16){bus.i_in[15]}}, bus.i_in} : '0;
        comb_x[1] = bus.in_valid ? {{(W-16){bus.q_in[15]}}, bus.q_in} : '0;
        for (int ch = 0; ch < 2; ch++) begin
            comb_c[ch][0] = comb_x[ch];
            for (int k = 0; k < N; k++) begin
                comb_c[ch][k+1] = comb_c[ch][k] - comb_dly[ch][k];
            end
        end
    end

    // Filter state: combs step on requests, integrators step on every DAC strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                comb_lat[ch] <= '0;
                for (int k = 0; k < N; k++) begin
                    comb_dly[ch][k] <= '0;
                    integ[ch][k]    <= '0;
                end
            end
            pending <= 1'b0;
        end else if (flush) begin
            for (int ch = 0; ch < 2; ch++) begin
                comb_lat[ch] <= '0;
                for (int k = 0; k < N; k++) begin
                    comb_dly[ch][k] <= '0;
                    integ[ch][k]    <= '0;
                end
            end
            pending <= 1'b0;
        end else begin
            if (interp_q) begin
                for (int ch = 0; ch < 2; ch++) begin
                    comb_lat[ch] <= comb_c[ch][N];
                    for (int k = 0; k < N; k++) begin
                        comb_dly[ch][k] <= comb_c[ch][k];
                    end
                end
            end
            if (bus.sample_strobe) begin
                for (int ch = 0; ch < 2; ch++) begin
                    integ[ch][0] <= integ[ch][0] + (pending ? comb_lat[ch] : '0);
                    for (int k = 1; k < N; k++) begin
                        integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
                    end
                end
            end
            if (interp_q) begin
                pending <= 1'b1;
            end else if (bus.sample_strobe) begin
                pending <= 1'b0;
            end
        end
    end

    // Priority-encode ceil(log2(rate)) as the bit length of rate-1, then triple it.
    always_comb begin
        log2_rate = 4'd0;
        for (int b = 0; b < 8; b++) begin
            if (rate_m1[b]) begin
                log2_rate = 4'(b + 1);
            end
        end
        shift = {1'b0, log2_rate} + {log2_rate, 1'b0};
    end

    // Gain normalisation: optional half-up bias, arithmetic shift, 16-bit saturation.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
`ifdef TX_CIC_ROUND_EN
            biased[ch] = {integ[ch][N-1][W-1], integ[ch][N-1]} + (ROUND_ONE <<< (shift - 5'd1));
`else
            biased[ch] = {integ[ch][N-1][W-1], integ[ch][N-1]};
`endif
            shifted[ch] = biased[ch] >>> shift;
            if (shifted[ch] > 41'sd32767) begin
                y[ch] = 16'sh7fff;
            end else if (shifted[ch] < -41'sd32768) begin
                y[ch] = 16'sh8000;
            end else begin
                y[ch] = shifted[ch][15:0];
            end
        end
    end

    // Output load is delayed one clock behind the strobe that advanced the integrators.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_q <= 1'b0;
        end else begin
            load_q <= strobe_ok;
        end
    end

    // Output registers hold between strobes and are forced to zero while disabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q[0] <= '0;
            out_q[1] <= '0;
        end else if (!bus.enable) begin
            out_q[0] <= '0;
            out_q[1] <= '0;
        end else if (load_q) begin
            out_q[0] <= y[0];
            out_q[1] <= y[1];
        end
    end

    // Sticky underrun: a request found no valid sample upstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underrun_q <= 1'b0;
        end else if (!bus.enable) begin
            underrun_q <= 1'b0;
        end else if (interp_q && !bus.in_valid) begin
            underrun_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tx_cic_interp.sv
// tb_tx_cic_interp: randomized and directed stimulus for tx_cic_interp,
// checked every clock against a transfer-function model of the CIC
// (binomial comb, closed-form integrator impulse response).
// Build with TX_CIC_ROUND_EN defined to check the rounding variant.
module tb_tx_cic_interp;
    localparam logic [6:0] RATEADDR = 7'd0;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   pulse_count;

    tx_cic_interp_if bus ();

    tx_cic_interp #(.RATEADDR(RATEADDR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model state
    int       m_rate;
    int       m_count;
    bit       m_interp;
    bit       m_pending;
    bit       m_load;
    bit       m_under;
    longint   m_comb_i, m_comb_q;
    longint   hist_i[4], hist_q[4];
    int       m_n;
    int       ev_n[$];
    longint   ev_i[$], ev_q[$];
    longint   m_yi, m_yq, m_out_i, m_out_q;

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic longint wrap40(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    function automatic longint scale(input longint v, input int rate);
        int     lg;
        int     sh;
        longint t;
        lg = 0;
        while ((1 << lg) < rate) lg++;
        sh = 3 * lg;
        t  = v;
`ifdef TX_CIC_ROUND_EN
        t = t + (longint'(1) <<< (sh - 1));
`endif
        t = t >>> sh;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction

    function automatic longint choose3(input int j);
        longint lj;
        lj = longint'(j);
        return (lj * (lj - 1) * (lj - 2)) / 6;
    endfunction

    task automatic clear_filters();
        for (int k = 0; k < 4; k++) begin
            hist_i[k] = 0;
            hist_q[k] = 0;
        end
        m_comb_i  = 0;
        m_comb_q  = 0;
        m_pending = 0;
        m_n       = 0;
        ev_n.delete();
        ev_i.delete();
        ev_q.delete();
    endtask

    task automatic model_reset();
        m_rate   = 4;
        m_count  = 0;
        m_interp = 0;
        m_load   = 0;
        m_under  = 0;
        m_yi = 0; m_yq = 0;
        m_out_i = 0; m_out_q = 0;
        clear_filters();
    endtask

    // One clock of the reference model, using the inputs the bench drove this cycle
    task automatic model_step();
        bit     en, ss, iv, hit, new_interp;
        longint xi, xq, ui, uq, acc_i, acc_q;
        int     wdata;
        if (reset) begin
            model_reset();
            return;
        end
        en    = bus.enable;
        ss    = bus.sample_strobe;
        iv    = bus.in_valid;
        hit   = bus.serial_strobe && (bus.serial_addr == RATEADDR);
        wdata = int'(bus.serial_data[7:0]);

        if (!en) begin
            m_out_i = 0; m_out_q = 0;
        end else if (m_load) begin
            m_out_i = m_yi; m_out_q = m_yq;
        end
        if (!en) m_under = 0;
        else if (m_interp && !iv) m_under = 1;
        m_load = en && !hit && ss;
        if (hit) m_rate = (wdata < 2) ? 2 : wdata;
        if (!en || hit) begin
            clear_filters();
            m_count  = 0;
            m_interp = 0;
            return;
        end

        ui = m_pending ? m_comb_i : 0;
        uq = m_pending ? m_comb_q : 0;
        new_interp = 0;
        if (m_interp) begin
            xi = iv ? longint'(bus.i_in) : 0;
            xq = iv ? longint'(bus.q_in) : 0;
            m_comb_i = xi - 4*hist_i[0] + 6*hist_i[1] - 4*hist_i[2] + hist_i[3];
            m_comb_q = xq - 4*hist_q[0] + 6*hist_q[1] - 4*hist_q[2] + hist_q[3];
            for (int k = 3; k > 0; k--) begin
                hist_i[k] = hist_i[k-1];
                hist_q[k] = hist_q[k-1];
            end
            hist_i[0] = xi;
            hist_q[0] = xq;
            m_pending = 1;
        end else if (ss) begin
            m_pending = 0;
        end
        if (ss) begin
            m_n++;
            if (ui != 0 || uq != 0) begin
                ev_n.push_back(m_n);
                ev_i.push_back(ui);
                ev_q.push_back(uq);
            end
            acc_i = 0;
            acc_q = 0;
            foreach (ev_n[e]) begin
                acc_i += ev_i[e] * choose3(m_n - ev_n[e]);
                acc_q += ev_q[e] * choose3(m_n - ev_n[e]);
            end
            m_yi = scale(wrap40(acc_i), m_rate);
            m_yq = scale(wrap40(acc_q), m_rate);
            if (m_count == m_rate - 1) begin
                m_count    = 0;
                new_interp = 1;
            end else begin
                m_count++;
            end
        end
        m_interp = new_interp;
    endtask

    // Drive one clock of inputs, advance the model, compare just after the edge
    task automatic apply_stimulus(input bit rst, input bit en, input bit ss, input bit iv,
                                  input logic signed [15:0] ii, input logic signed [15:0] qq,
                                  input bit sw, input logic [6:0] addr, input logic [31:0] data);
        @(negedge clock);
        reset             = rst;
        bus.enable        = en;
        bus.sample_strobe = ss;
        bus.in_valid      = iv;
        bus.i_in          = ii;
        bus.q_in          = qq;
        bus.serial_strobe = sw;
        bus.serial_addr   = addr;
        bus.serial_data   = data;
        @(posedge clock);
        model_step();
        #1;
        check_output("interp_strobe", longint'(bus.interp_strobe), longint'(m_interp));
        check_output("underrun", longint'(bus.underrun), longint'(m_under));
        check_output("i_out", longint'(bus.i_out), m_out_i);
        check_output("q_out", longint'(bus.q_out), m_out_q);
        if (bus.interp_strobe) pulse_count++;
    endtask

    task automatic run(input bit ss, input bit iv, input logic signed [15:0] ii, input logic signed [15:0] qq);
        apply_stimulus(1'b0, 1'b1, ss, iv, ii, qq, 1'b0, 7'd0, 32'd0);
    endtask

    task automatic write_rate(input bit ss, input logic [31:0] data,
                              input logic signed [15:0] ii, input logic signed [15:0] qq);
        apply_stimulus(1'b0, 1'b1, ss, 1'b1, ii, qq, 1'b1, RATEADDR, data);
    endtask

    function automatic logic signed [15:0] rnd16();
        logic [31:0] r;
        r = $urandom;
        return r[15:0];
    endfunction

    initial begin
        int          guard;
        int          rates[8];
        logic [31:0] rdata;
        checks   = 0;
        failures = 0;
        rates    = '{0, 1, 2, 3, 4, 5, 8, 16};
        reset             = 1'b1;
        bus.enable        = 1'b0;
        bus.sample_strobe = 1'b0;
        bus.in_valid      = 1'b0;
        bus.i_in          = '0;
        bus.q_in          = '0;
        bus.serial_strobe = 1'b0;
        bus.serial_addr   = '0;
        bus.serial_data   = '0;
        model_reset();

        $display("[TB] reset and defaults");
        repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'sd0, 16'sd0, 1'b0, 7'd0, 32'd0);
        check_output("reset_i_out", longint'(bus.i_out), 0);
        check_output("reset_interp", longint'(bus.interp_strobe), 0);
        check_output("reset_underrun", longint'(bus.underrun), 0);
        for (int k = 0; k < 20; k++) begin
            run(1'b1, 1'b1, rnd16(), rnd16());
            run(1'b0, 1'b1, rnd16(), rnd16());
        end
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 16'sd5000, 16'sd5000, 1'b0, 7'd0, 32'd0);
        check_output("midreset_i_out", longint'(bus.i_out), 0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'sd5000, 16'sd5000, 1'b0, 7'd0, 32'd0);
        check_output("midreset_q_out", longint'(bus.q_out), 0);
        pulse_count = 0;
        for (int k = 0; k < 16; k++) begin
            run(1'b1, 1'b1, rnd16(), rnd16());
            run(1'b0, 1'b1, rnd16(), rnd16());
        end
        check_output("rate4_pulses", pulse_count, 4);

        $display("[TB] DC gain at rate 4");
        write_rate(1'b0, 32'd4, 16'sd1000, -16'sd1000);
        for (int k = 0; k < 48; k++) begin
            run(1'b1, 1'b1, 16'sd1000, -16'sd1000);
            run(1'b0, 1'b1, 16'sd1000, -16'sd1000);
            run(1'b0, 1'b1, 16'sd1000, -16'sd1000);
        end
        check_output("dc4_i", longint'(bus.i_out), 1000);
        check_output("dc4_q", longint'(bus.q_out), -1000);

        $display("[TB] non-power-of-two rate 3");
        write_rate(1'b0, 32'd3, 16'sd32767, -16'sd32767);
        for (int k = 0; k < 60; k++) begin
            run(1'b1, 1'b1, 16'sd32767, -16'sd32767);
            run(1'b0, 1'b1, 16'sd32767, -16'sd32767);
        end
`ifdef TX_CIC_ROUND_EN
        check_output("rate3_i", longint'(bus.i_out), 13824);
`else
        check_output("rate3_i", longint'(bus.i_out), 13823);
`endif

        $display("[TB] rate clamp mid-stream");
        write_rate(1'b0, 32'd4, 16'sd1000, 16'sd1000);
        for (int k = 0; k < 20; k++) begin
            run(1'b1, 1'b1, 16'sd1000, 16'sd1000);
            run(1'b0, 1'b1, 16'sd1000, 16'sd1000);
        end
        write_rate(1'b0, 32'hABCD_0001, 16'sd1000, 16'sd1000);
        pulse_count = 0;
        for (int k = 0; k < 16; k++) begin
            run(1'b1, 1'b1, 16'sd1000, 16'sd1000);
            run(1'b0, 1'b1, 16'sd1000, 16'sd1000);
        end
        check_output("rate2_pulses", pulse_count, 8);

        $display("[TB] underrun");
        write_rate(1'b0, 32'd4, 16'sd1000, 16'sd1000);
        for (int k = 0; k < 60; k++) begin
            run(1'b1, 1'b1, 16'sd1000, 16'sd1000);
            run(1'b0, 1'b1, 16'sd1000, 16'sd1000);
        end
        check_output("pre_underrun", longint'(bus.underrun), 0);
        guard = 0;
        while (!m_interp && guard < 20) begin
            run(1'b1, 1'b1, 16'sd1000, 16'sd1000);
            guard++;
        end
        run(1'b0, 1'b0, 16'sd1000, 16'sd1000);
        check_output("underrun_set", longint'(bus.underrun), 1);
        for (int k = 0; k < 60; k++) begin
            run(1'b1, 1'b1, 16'sd1000, 16'sd1000);
            run(1'b0, 1'b1, 16'sd1000, 16'sd1000);
        end
        check_output("underrun_sticky", longint'(bus.underrun), 1);
        check_output("underrun_recover", longint'(bus.i_out), 1000);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'sd1000, 16'sd1000, 1'b0, 7'd0, 32'd0);
        check_output("disable_i_out", longint'(bus.i_out), 0);
        check_output("disable_q_out", longint'(bus.q_out), 0);
        check_output("disable_underrun", longint'(bus.underrun), 0);

        $display("[TB] serial write colliding with sample_strobe");
        write_rate(1'b0, 32'd4, 16'sd700, 16'sd700);
        guard = 0;
        while (m_count != 3 && guard < 10) begin
            run(1'b1, 1'b1, 16'sd700, 16'sd700);
            guard++;
        end
        write_rate(1'b1, 32'd4, 16'sd700, 16'sd700);
        check_output("collision_interp", longint'(bus.interp_strobe), 0);
        pulse_count = 0;
        repeat (3) run(1'b1, 1'b1, 16'sd700, 16'sd700);
        check_output("collision_restart", pulse_count, 0);
        run(1'b1, 1'b1, 16'sd700, 16'sd700);
        check_output("collision_first", pulse_count, 1);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 1500; k++) begin
            rdata = $urandom;
            rdata[7:0] = 8'(rates[$urandom_range(0, 7)]);
            apply_stimulus($urandom_range(0, 999) < 2,
                           $urandom_range(0, 99) >= 2,
                           $urandom_range(0, 2) == 0,
                           $urandom_range(0, 99) >= 5,
                           rnd16(), rnd16(),
                           $urandom_range(0, 99) < 1,
                           ($urandom_range(0, 1) == 0) ? RATEADDR : 7'd5,
                           rdata);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_cic_interp.md
# tx_cic_interp

Transmit-side counterpart of the receive decimation chain. It accepts baseband I/Q samples from the TX FIFO side at the interpolated input rate and runs a 4-stage CIC interpolator per channel. It produces I/Q at the DAC sample-strobe rate, handing off to the TX upconversion / DAC formatting stage. The interpolation rate comes from the serial control bus. The block generates the input-request strobe for upstream.

## Interface
- `RATEADDR`, default 0: serial register address of the interpolation-rate register.
- `clock` in 1: system clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: TX path enable; low clears all datapath state.
- `serial_addr` in 7: serial bus address.
- `serial_data` in 32: serial bus data.
- `serial_strobe` in 1: one-cycle write strobe.
- `sample_strobe` in 1: output-rate (DAC) strobe, one cycle wide.
- `i_in`, `q_in` in 16 each: signed input samples; valid when `in_valid` is high.
- `in_valid` in 1: upstream has a sample available.
- `interp_strobe` out 1: one-cycle request; I/Q are consumed in this cycle.
- `i_out`, `q_out` out 16 each: signed interpolated outputs.
- `underrun` out 1: sticky flag; a request was made while `in_valid` was low.

## Operation
- **Rate register**
  - A write with `serial_strobe` high and `serial_addr==RATEADDR` loads `rate = serial_data[7:0]`.
  - Written values 0 or 1 are stored as 2. Legal range is 2..255.
  - Reset value is 4.
  - The write also clears the strobe counter and all comb, integrator and pending state in the same clock.
- **Strobe counter**
  - 8 bits, reset value 0.
  - On each `sample_strobe` with `enable` high:
    - if `count==rate-1`: set `count<=0` and assert registered `interp_strobe` in the next clock;
    - otherwise `count<=count+1`.
  - Result: exactly one `interp_strobe` per `rate` sample strobes.
- **Input accept**
  - In the `interp_strobe` cycle, the block takes `x = in_valid ? i_in/q_in : 0`.
  - If `in_valid` is low, `underrun<=1`.
- **Comb section** (input rate)
  - Four differentiators, each `c_k = c_{k-1} - delay`, updated only in `interp_strobe` cycles.
  - Width is 40 bits, sign-extended from the input.
  - The final comb output is latched together with `pending<=1`.
- **Integrator section** (output rate)
  - Four accumulators, 40 bits, two's-complement wrap.
  - Updated on each `sample_strobe`.
  - The first integrator input is the latched comb value when `pending` is set (which also clears `pending`); otherwise it is 0 (zero-stuffing).
- **Scaling**
  - `shift = 3*ceil(log2(rate))`, computed from `rate` by a priority encoder.
  - `y = int4 >>> shift` (arithmetic), then saturated to [-32768, 32767].
  - Gain is exactly 1 for power-of-two rates; otherwise it is `rate^3 / 2^shift` (< 1).
- **Output register**
  - `i_out`/`q_out` load `y` in the clock after each `sample_strobe`.
  - They hold between strobes.
- **Enable low**
  - Synchronously clears the counter, comb, integrator and pending state, and `underrun`.
  - Forces outputs to 0 and suppresses `interp_strobe`.
  - The rate register is kept.

## Timing
- **Reset values:** `interp_strobe=0`, `i_out=q_out=0`, `underrun=0`, `rate=4`, `count=0`, all filter state 0.
- `interp_strobe` is high one clock after the wrapping `sample_strobe`. It is never high in two consecutive clocks.
- **Comb latency:** the comb value is latched in the `interp_strobe` clock. It enters the integrators at the next `sample_strobe`.
- **Output latency:** `i_out` is valid one clock after that `sample_strobe`.
- **Serial write and `sample_strobe` in the same clock:** the write wins and the strobe is ignored.
- **`sample_strobe` in the same clock as `interp_strobe`:** the integrators use the previous pending value (or 0). The new comb value waits for the next strobe.
- **`enable` falling mid-operation:** state clears in that clock. After `enable` rises, counting restarts from 0.
- **Reset asserted mid-operation:** immediate, asynchronous return to the reset values.

## Configuration
- Macro `TX_CIC_ROUND_EN`.
  - Defined: before the shift, add `1<<(shift-1)` to `int4` (round half up). Saturation follows the rounding.
  - Undefined: plain arithmetic-shift truncation.
- All other behaviour is identical in both builds.

## Test plan
- **Reset and defaults:** assert `reset` mid-stream, then `sample_strobe` every 2 clocks with `enable=1`, `in_valid=1` → outputs 0 during reset; `interp_strobe` afterwards every 4th `sample_strobe` (rate 4).
- **DC gain, rate 4:** constant `i_in=1000`, `q_in=-1000` → after 5 input samples, `i_out=1000` and `q_out=-1000` exactly on every strobe, in both builds.
- **Non-power-of-two, rate 3:** write `serial_data=3`; constant input 32767 → settles at 13823 without `TX_CIC_ROUND_EN`, 13824 with it.
- **Rate clamp and mid-stream write:** write 1 while running → `rate` reads back as 2; counter and filters clear in the same clock; `interp_strobe` every 2nd strobe afterwards.
- **Underrun:** hold `in_valid=0` on one `interp_strobe` at steady state → `underrun` goes to 1 and stays 1; the output dips, then recovers to 1000. Dropping `enable` clears `underrun` and forces outputs to 0.
- **Collision:** serial write to `RATEADDR` coincident with `sample_strobe` → no `interp_strobe` results from that strobe, and `count` is 0 afterwards.
